pairing_wport_arb: RTL and testbench

Write-port arbiter for the pairing core's two operand BRAMs (RAM0/RAM1), which share one write address and one data bus. It merges three writers onto the single registered write port: the external host loader, the fixed-latency pipeline writeback, and the Montgomery inverse unit. Pipeline writeback cannot stall, so inverse results that collide with it are parked in a small FIFO and drained into idle slots. A read-after-write hazard flag tells the sequencer when an operand it is about to fetch is still parked.

---
 rtl/pairing_wport_arb_if.sv | 50 +++++
 rtl/pairing_wport_arb.sv | 167 ++++++++++++++++
 tb/tb_pairing_wport_arb.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pairing_wport_arb_if.sv
// Bus bundle for the BRAM write-port arbiter.
// master: the core side (sequencer, host loader, pipeline, inverse unit),
//         drives the three writer inputs and rd_addr, observes the write port.
// slave : the arbiter, drives the registered write port, FIFO status,
//         hazard and overflow flags.
interface pairing_wport_arb_if #(
    parameter int unsigned DW    = 1216,
    parameter int unsigned AW    = 9,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // writer inputs
    logic          busy;
    logic          ext_en;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_data;
    logic          pipe_me0;
    logic          pipe_me1;
    logic [AW-1:0] pipe_addr;
    logic [DW-1:0] pipe_data;
    logic          inv_vld;
    logic [AW-1:0] inv_addr;
    logic [DW-1:0] inv_data;
    logic [AW-1:0] rd_addr;

    // write port and status
    logic          me0;
    logic          me1;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          inv_pend;
    logic [CW-1:0] fifo_cnt;
    logic          hazard;
    logic          ovf;

    modport master (
        output busy, ext_en, ext_addr, ext_data,
        output pipe_me0, pipe_me1, pipe_addr, pipe_data,
        output inv_vld, inv_addr, inv_data, rd_addr,
        input  me0, me1, waddr, wdata, inv_pend, fifo_cnt, hazard, ovf
    );

    modport slave (
        input  busy, ext_en, ext_addr, ext_data,
        input  pipe_me0, pipe_me1, pipe_addr, pipe_data,
        input  inv_vld, inv_addr, inv_data, rd_addr,
        output me0, me1, waddr, wdata, inv_pend, fifo_cnt, hazard, ovf
    );
endinterface

// File: rtl/pairing_wport_arb.sv
// Write-port arbiter for the pairing core's two operand BRAMs.
// Merges host loader, pipeline writeback and Montgomery inverse results onto
// one registered write port. Inverse results that lose to the pipeline are
// parked in an in-order FIFO and drained into idle slots.
// Ports:
//   clk  - clock
//   rstn - synchronous active-low reset
//   bus  - pairing_wport_arb_if.slave: writer inputs, rd_addr, registered
//          write port (me0/me1/waddr/wdata), inv_pend, fifo_cnt, hazard, ovf
module pairing_wport_arb #(
    parameter int unsigned DW    = 1216,
    parameter int unsigned AW    = 9,
    parameter int unsigned DEPTH = 4
) (
    input logic               clk,
    input logic               rstn,
    pairing_wport_arb_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_HOST,
        SRC_PIPE,
        SRC_FIFO,
        SRC_BYP
    } src_e;

    src_e          src;
    logic          pipe_act, empty, full;
    logic          pop, push_req, push;

    logic [AW-1:0] q_addr [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [DEPTH-1:0] q_vld_q, q_vld_d;
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q;
    logic          ovf_q, ovf_d;

    logic          me0_q, me0_d, me1_q, me1_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          hazard;

    // Source selection for the next registered write.
    always_comb begin
        pipe_act = bus.pipe_me0 || bus.pipe_me1;
        empty    = (cnt_q == '0);
        full     = (cnt_q == CW'(DEPTH));
        src      = SRC_NONE;
        if (!bus.busy)          src = SRC_HOST;
        else if (pipe_act)      src = SRC_PIPE;
        else if (!empty)        src = SRC_FIFO;
        else if (bus.inv_vld)   src = SRC_BYP;
        pop      = (src == SRC_FIFO);
        push_req = bus.inv_vld && (src != SRC_BYP);
        // a simultaneous pop frees the slot, so a full FIFO still accepts
        push     = push_req && (!full || pop);
    end

    always_comb begin
        me0_d   = 1'b0;
        me1_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (src)
            SRC_HOST: begin
                me0_d   = bus.ext_en;
                me1_d   = bus.ext_en;
                waddr_d = bus.ext_addr;
                wdata_d = bus.ext_data;
            end
            SRC_PIPE: begin
                me0_d   = bus.pipe_me0;
                me1_d   = bus.pipe_me1;
                waddr_d = bus.pipe_addr;
                wdata_d = bus.pipe_data;
            end
            SRC_FIFO: begin
                me0_d   = 1'b1;
                me1_d   = 1'b1;
                waddr_d = q_addr[rptr_q];
                wdata_d = q_data[rptr_q];
            end
            SRC_BYP: begin
                me0_d   = 1'b1;
                me1_d   = 1'b1;
                waddr_d = bus.inv_addr;
                wdata_d = bus.inv_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        q_vld_d = q_vld_q;
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);
        if (pop) begin
            rptr_d          = rptr_q + PW'(1);
            q_vld_d[rptr_q] = 1'b0;
        end
        // set after clear: on full push+pop both pointers address one slot
        if (push) begin
            wptr_d          = wptr_q + PW'(1);
            q_vld_d[wptr_q] = 1'b1;
        end
        ovf_d = ovf_q || (push_req && full && !pop);
    end

    // A bypassed result is written next cycle without parking, so it is
    // deliberately left out of the hazard.
    always_comb begin
        hazard = bus.inv_vld && (src != SRC_BYP) && (bus.inv_addr == bus.rd_addr);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (q_vld_q[i] && (q_addr[i] == bus.rd_addr)) hazard = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            me0_q   <= 1'b0;
            me1_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            q_vld_q <= '0;
        end else begin
            me0_q   <= me0_d;
            me1_q   <= me1_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            pend_q  <= (cnt_d != '0);
            ovf_q   <= ovf_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            q_vld_q <= q_vld_d;
        end
    end

    // Entry payload needs no reset; validity is tracked by q_vld_q.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wptr_q] <= bus.inv_addr;
            q_data[wptr_q] <= bus.inv_data;
        end
    end

    assign bus.me0      = me0_q;
    assign bus.me1      = me1_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign bus.inv_pend = pend_q;
    assign bus.fifo_cnt = cnt_q;
    assign bus.hazard   = hazard;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_pairing_wport_arb.sv
// Directed bench for pairing_wport_arb. Expected writes are queued by the
// stimulus; a negedge monitor pops and compares every write the DUT presents.
module tb_pairing_wport_arb;
    localparam int unsigned DW    = 64;
    localparam int unsigned AW    = 9;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic          m0;
        logic          m1;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic mon_en = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    wr_t  exp_q[$];

    always #5 clk = ~clk;

    pairing_wport_arb_if #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) bus ();

    pairing_wport_arb #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expw(input logic m0, input logic m1, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.m0 = m0; w.m1 = m1; w.a = a; w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic clr_inputs();
        bus.ext_en    = 1'b0;
        bus.ext_addr  = '0;
        bus.ext_data  = '0;
        bus.pipe_me0  = 1'b0;
        bus.pipe_me1  = 1'b0;
        bus.pipe_addr = '0;
        bus.pipe_data = '0;
        bus.inv_vld   = 1'b0;
        bus.inv_addr  = '0;
        bus.inv_data  = '0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (mon_en && (bus.me0 || bus.me1)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL write: unexpected me0=%0b me1=%0b addr=%0h data=%0h",
                         bus.me0, bus.me1, bus.waddr, bus.wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.me0 !== e.m0 || bus.me1 !== e.m1 || bus.waddr !== e.a || bus.wdata !== e.d) begin
                    n_err++;
                    $display("FAIL write: got me0=%0b me1=%0b addr=%0h data=%0h, expected me0=%0b me1=%0b addr=%0h data=%0h",
                             bus.me0, bus.me1, bus.waddr, bus.wdata, e.m0, e.m1, e.a, e.d);
                end
            end
        end
    end

    initial begin
        clr_inputs();
        bus.busy    = 1'b0;
        bus.rd_addr = '0;
        rstn        = 1'b0;
        step();
        step();
        chk("rst_me0",   DW'(bus.me0), '0);
        chk("rst_me1",   DW'(bus.me1), '0);
        chk("rst_waddr", DW'(bus.waddr), '0);
        chk("rst_wdata", bus.wdata, '0);
        chk("rst_cnt",   DW'(bus.fifo_cnt), '0);
        chk("rst_pend",  DW'(bus.inv_pend), '0);
        chk("rst_ovf",   DW'(bus.ovf), '0);
        rstn   = 1'b1;
        mon_en = 1'b1;

        // host load, pipeline strobes ignored
        bus.busy = 1'b0;
        bus.ext_en = 1'b1; bus.ext_addr = 9'h005; bus.ext_data = 64'hA5;
        bus.pipe_me0 = 1'b1; bus.pipe_me1 = 1'b1; bus.pipe_addr = 9'h077; bus.pipe_data = 64'h77;
        expw(1'b1, 1'b1, 9'h005, 64'hA5);
        step();
        clr_inputs();

        // inverse result while host owns the port: parked, not drained
        bus.inv_vld = 1'b1; bus.inv_addr = 9'h040; bus.inv_data = 64'h4040;
        step();
        clr_inputs();
        chk("host_enq_cnt", DW'(bus.fifo_cnt), 64'd1);
        step();
        step();
        chk("host_hold_cnt", DW'(bus.fifo_cnt), 64'd1);
        bus.busy = 1'b1;
        expw(1'b1, 1'b1, 9'h040, 64'h4040);
        step();
        chk("host_drain_cnt", DW'(bus.fifo_cnt), 64'd0);
        chk("host_drain_pend", DW'(bus.inv_pend), 64'd0);

        // bypass
        bus.inv_vld = 1'b1; bus.inv_addr = 9'h01F; bus.inv_data = 64'h1F1F;
        bus.rd_addr = 9'h01F;
        #1;
        chk("byp_hazard", DW'(bus.hazard), 64'd0);
        expw(1'b1, 1'b1, 9'h01F, 64'h1F1F);
        step();
        clr_inputs();
        chk("byp_cnt", DW'(bus.fifo_cnt), 64'd0);

        // collision
        bus.pipe_me0 = 1'b1; bus.pipe_addr = 9'h010; bus.pipe_data = 64'h1010;
        bus.inv_vld = 1'b1; bus.inv_addr = 9'h020; bus.inv_data = 64'h2020;
        expw(1'b1, 1'b0, 9'h010, 64'h1010);
        expw(1'b1, 1'b1, 9'h020, 64'h2020);
        step();
        clr_inputs();
        chk("col_cnt", DW'(bus.fifo_cnt), 64'd1);
        chk("col_pend", DW'(bus.inv_pend), 64'd1);
        step();
        chk("col_cnt2", DW'(bus.fifo_cnt), 64'd0);
        chk("col_pend2", DW'(bus.inv_pend), 64'd0);

        // hazard
        bus.pipe_me1 = 1'b1; bus.pipe_addr = 9'h011; bus.pipe_data = 64'h1111;
        bus.inv_vld = 1'b1; bus.inv_addr = 9'h033; bus.inv_data = 64'h3333;
        bus.rd_addr = 9'h033;
        #1;
        chk("hz_live", DW'(bus.hazard), 64'd1);
        expw(1'b0, 1'b1, 9'h011, 64'h1111);
        step();
        bus.inv_vld = 1'b0;
        bus.pipe_addr = 9'h012; bus.pipe_data = 64'h1212;
        expw(1'b0, 1'b1, 9'h012, 64'h1212);
        #1;
        chk("hz_parked", DW'(bus.hazard), 64'd1);
        bus.rd_addr = 9'h034;
        #1;
        chk("hz_other", DW'(bus.hazard), 64'd0);
        step();
        clr_inputs();
        bus.rd_addr = 9'h033;
        #1;
        chk("hz_still", DW'(bus.hazard), 64'd1);
        expw(1'b1, 1'b1, 9'h033, 64'h3333);
        step();
        chk("hz_drained", DW'(bus.hazard), 64'd0);
        chk("hz_cnt", DW'(bus.fifo_cnt), 64'd0);
        bus.rd_addr = '0;

        // overflow
        for (int i = 0; i < 6; i++) begin
            bus.pipe_me0 = 1'b1; bus.pipe_me1 = 1'b1;
            bus.pipe_addr = AW'(9'h050 + i); bus.pipe_data = DW'(64'h5000 + i);
            bus.inv_vld = 1'b1;
            bus.inv_addr = AW'(9'h060 + i); bus.inv_data = DW'(64'h6000 + i);
            expw(1'b1, 1'b1, AW'(9'h050 + i), DW'(64'h5000 + i));
            step();
            chk("ovf_cnt", DW'(bus.fifo_cnt), DW'((i + 1 > 4) ? 4 : i + 1));
            chk("ovf_flag", DW'(bus.ovf), DW'((i >= 4) ? 1 : 0));
        end
        clr_inputs();
        for (int i = 0; i < 4; i++) expw(1'b1, 1'b1, AW'(9'h060 + i), DW'(64'h6000 + i));
        for (int i = 0; i < 4; i++) step();
        chk("ovf_drain_cnt", DW'(bus.fifo_cnt), 64'd0);
        chk("ovf_sticky", DW'(bus.ovf), 64'd1);

        // reset with entries parked
        for (int i = 0; i < 3; i++) begin
            bus.pipe_me0 = 1'b1; bus.pipe_me1 = 1'b1;
            bus.pipe_addr = AW'(9'h080 + i); bus.pipe_data = DW'(64'h8000 + i);
            bus.inv_vld = 1'b1;
            bus.inv_addr = AW'(9'h070 + i); bus.inv_data = DW'(64'h7000 + i);
            expw(1'b1, 1'b1, AW'(9'h080 + i), DW'(64'h8000 + i));
            step();
        end
        clr_inputs();
        chk("mr_pre_cnt", DW'(bus.fifo_cnt), 64'd3);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("mr_cnt", DW'(bus.fifo_cnt), 64'd0);
        chk("mr_ovf", DW'(bus.ovf), 64'd0);
        chk("mr_pend", DW'(bus.inv_pend), 64'd0);
        chk("mr_me0", DW'(bus.me0), 64'd0);
        for (int i = 0; i < 5; i++) step();
        chk("sb_empty", DW'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
